// File: rtl/mul_seq_param_if.sv
// Handshake and operand bundle for the sequential multiplier.
// The master drives the request side; the slave (the multiplier) drives status and result.
interface mul_seq_param_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic                   start;
    logic [3:0]             dtype;
    logic                   abort;
    logic [WIDTH-1:0]       M;
    logic [WIDTH-1:0]       Q;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, dtype, abort, M, Q,
        input  busy, done, result
    );

    modport slave (
        input  start, dtype, abort, M, Q,
        output busy, done, result
    );
endinterface

// File: rtl/mul_seq_param.sv
// Sequential WIDTH x WIDTH multiplier: unsigned shift-add or signed radix-2 Booth,
// one bit per cycle, with busy/done handshake, synchronous abort and a held result.
module mul_seq_param #(
    parameter int unsigned WIDTH   = 16,
    parameter logic [3:0]  DTYPE_U = 4'h2,
    parameter logic [3:0]  DTYPE_S = 4'h3
) (
    input  logic           clk,
    input  logic           n_rst,
    mul_seq_param_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 sgn_q, sgn_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       a_base;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       a_step;
    logic [WIDTH-1:0]     q_step;
    logic [2*WIDTH-1:0]   product;
    logic                 accept;

    // One iteration. A carries an extra bit: the carry in unsigned mode, the sign in signed
    // mode, so that M = -2^(WIDTH-1) is handled exactly.
    always_comb begin
        m_ext  = sgn_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
        a_base = sgn_q ? a_q : {1'b0, a_q[WIDTH-1:0]};
        sum    = a_base;
        if (sgn_q) begin
            unique case ({q_q[0], q1_q})
                2'b10:   sum = a_base - m_ext;
                2'b01:   sum = a_base + m_ext;
                default: sum = a_base;
            endcase
        end else if (q_q[0]) begin
            sum = a_base + m_ext;
        end
        a_step  = {sgn_q & sum[WIDTH], sum[WIDTH:1]};
        q_step  = {sum[0], q_q[WIDTH-1:1]};
        product = {a_q[WIDTH-1:0], q_q};
    end

    assign accept = bus.start && ((bus.dtype == DTYPE_U) || (bus.dtype == DTYPE_S));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        sgn_d    = sgn_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                    m_d     = bus.M;
                    q_d     = bus.Q;
                    sgn_d   = (bus.dtype == DTYPE_S);
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CntW'(WIDTH - 1);
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    a_d  = a_step;
                    q_d  = q_step;
                    q1_d = q_q[0];
                    if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!bus.abort) begin
                    result_d = product;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            sgn_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
        end
    end

    // The product is presented while done is high and captured into result_q on that edge,
    // so an abort in the DONE cycle suppresses both done and the update.
    assign bus.busy   = (state_q == StRun) || (state_q == StDone);
    assign bus.done   = (state_q == StDone) && !bus.abort;
    assign bus.result = bus.done ? product : result_q;
endmodule

// File: tb/tb_mul_seq_param.sv
// Self-checking bench: directed cases on a WIDTH=16 instance, randomized sweep on WIDTH=8,
// both against an arithmetic reference product.
module tb_mul_seq_param;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    mul_seq_param_if #(.WIDTH(16)) if16 ();
    mul_seq_param_if #(.WIDTH(8))  if8 ();

    mul_seq_param #(.WIDTH(16)) dut16 (.clk(clk), .n_rst(n_rst), .bus(if16));
    mul_seq_param #(.WIDTH(8))  dut8  (.clk(clk), .n_rst(n_rst), .bus(if8));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q,
                                             input int w, input bit sgn);
        longint a, b, mask;
        mask = (longint'(1) << w) - 1;
        a = longint'(m) & mask;
        b = longint'(q) & mask;
        if (sgn) begin
            if (((a >> (w - 1)) & 1) != 0) a -= (longint'(1) << w);
            if (((b >> (w - 1)) & 1) != 0) b -= (longint'(1) << w);
        end
        return 64'((a * b) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Issue one op on the 16-bit DUT and watch 24 cycles after the accept edge.
    task automatic run16(input logic [15:0] m, input logic [15:0] q, input logic [3:0] dt,
                         input int abort_cyc, input bit spur, input bit abort_acc,
                         output int ndone, output int lat, output logic [31:0] res);
        @(posedge clk); #1;
        if16.start = 1'b1; if16.M = m; if16.Q = q; if16.dtype = dt; if16.abort = abort_acc;
        ndone = 0; lat = 0; res = '0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if16.start = spur && (c == 3 || c == 10);
            if (if16.start) begin
                if16.M = 16'($urandom);
                if16.Q = 16'($urandom);
            end
            if16.abort = (c == abort_cyc);
            #1;
            if (if16.done) begin
                ndone++;
                if (lat == 0) lat = c;
                res = if16.result;
            end
        end
        if16.start = 1'b0;
        if16.abort = 1'b0;
    endtask

    int nd, lt;
    logic [31:0] rs, prev;

    initial begin
        if16.start = 0; if16.dtype = 0; if16.abort = 0; if16.M = 0; if16.Q = 0;
        if8.start = 0;  if8.dtype = 0;  if8.abort = 0;  if8.M = 0;  if8.Q = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 64'(if16.busy), 64'd0);
        check_eq("reset_done", 64'(if16.done), 64'd0);
        check_eq("reset_result", 64'(if16.result), 64'd0);
        check_eq("reset_result8", 64'(if8.result), 64'd0);
        n_rst = 1'b1;

        run16(16'hFFFF, 16'hFFFF, 4'h2, 0, 1'b0, 1'b0, nd, lt, rs);
        check_eq("u_ffff_ndone", 64'(nd), 64'd1);
        check_eq("u_ffff_lat", 64'(lt), 64'd17);
        check_eq("u_ffff_res", 64'(rs), 64'hFFFE0001);
        check_eq("u_ffff_hold", 64'(if16.result), 64'hFFFE0001);
        check_eq("u_ffff_idle", 64'(if16.busy), 64'd0);

        run16(16'h8000, 16'h8000, 4'h3, 0, 1'b0, 1'b0, nd, lt, rs);
        check_eq("s_min_res", 64'(rs), 64'h40000000);
        check_eq("s_min_lat", 64'(lt), 64'd17);
        run16(16'hFFFD, 16'h0005, 4'h3, 0, 1'b0, 1'b0, nd, lt, rs);
        check_eq("s_neg_res", 64'(rs), 64'hFFFFFFF1);

        run16(16'h1234, 16'h5678, 4'h2, 0, 1'b1, 1'b0, nd, lt, rs);
        check_eq("spur_ndone", 64'(nd), 64'd1);
        check_eq("spur_res", 64'(rs), ref_prod(32'h1234, 32'h5678, 16, 1'b0));

        prev = if16.result;
        run16(16'hABCD, 16'h1234, 4'h3, 8, 1'b0, 1'b0, nd, lt, rs);
        check_eq("abort_ndone", 64'(nd), 64'd0);
        check_eq("abort_hold", 64'(if16.result), 64'(prev));
        check_eq("abort_idle", 64'(if16.busy), 64'd0);
        run16(16'hABCD, 16'h1234, 4'h3, 0, 1'b0, 1'b0, nd, lt, rs);
        check_eq("post_abort_res", 64'(rs), ref_prod(32'hABCD, 32'h1234, 16, 1'b1));

        run16(16'h8001, 16'h7FFF, 4'h3, 0, 1'b0, 1'b1, nd, lt, rs);
        check_eq("start_over_abort_ndone", 64'(nd), 64'd1);
        check_eq("start_over_abort_res", 64'(rs), ref_prod(32'h8001, 32'h7FFF, 16, 1'b1));

        run16(16'h0007, 16'h0009, 4'h1, 0, 1'b0, 1'b0, nd, lt, rs);
        check_eq("bad_dtype_ndone", 64'(nd), 64'd0);
        check_eq("bad_dtype_busy", 64'(if16.busy), 64'd0);

        @(posedge clk); #1;
        if16.start = 1'b1; if16.M = 16'h00FF; if16.Q = 16'h0101; if16.dtype = 4'h2;
        @(posedge clk); #1;
        if16.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_eq("midrun_busy", 64'(if16.busy), 64'd1);
        n_rst = 1'b0;
        #1;
        check_eq("rst_busy", 64'(if16.busy), 64'd0);
        check_eq("rst_done", 64'(if16.done), 64'd0);
        check_eq("rst_result", 64'(if16.result), 64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            int sel;
            logic [7:0] m, q;
            logic [3:0] dt;
            int lat8;
            m = 8'($urandom);
            q = 8'($urandom);
            sel = int'($urandom_range(0, 7));
            dt = (sel == 0) ? 4'h5 : ((sel % 2 == 1) ? 4'h2 : 4'h3);
            @(posedge clk); #1;
            if8.start = 1'b1; if8.M = m; if8.Q = q; if8.dtype = dt;
            @(posedge clk); #1;
            if8.start = 1'b0; if8.M = 8'($urandom); if8.Q = 8'($urandom); if8.dtype = 4'($urandom);
            if (sel == 0) begin
                check_eq("r8_bad_dtype_busy", 64'(if8.busy), 64'd0);
                continue;
            end
            lat8 = 1;
            while (!if8.done && lat8 < 20) begin
                @(posedge clk); #1;
                lat8++;
            end
            check_eq("r8_lat", 64'(lat8), 64'd9);
            check_eq("r8_res", 64'(if8.result), ref_prod(32'(m), 32'(q), 8, dt == 4'h3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
